// File: rtl/riscv_memreq_issue_if.sv
// MMU-stage request / BIU strobe-ack bundle seen by the memory request issuer.
// master = the issuer, slave = the MMU/BIU environment around it.
interface riscv_memreq_issue_if #(
    parameter int XLEN = 32,
    parameter int PLEN = (XLEN == 32) ? 34 : 56
);
    typedef logic [2:0] biu_size_t;

    logic              flush_i;
    logic              req_i;
    logic [PLEN-1:0]   adr_i;
    biu_size_t         size_i;
    logic              lock_i;
    logic              we_i;
    logic [XLEN-1:0]   d_i;
    logic              misaligned_i;
    logic              pagefault_i;
    logic              stall_o;

    logic              biu_stb_o;
    logic [PLEN-1:0]   biu_adr_o;
    biu_size_t         biu_size_o;
    logic              biu_lock_o;
    logic              biu_we_o;
    logic [XLEN-1:0]   biu_d_o;
    logic              biu_stb_ack_i;
    logic              biu_ack_i;
    logic              biu_err_i;
    logic [XLEN-1:0]   biu_q_i;

    logic              ack_o;
    logic              err_o;
    logic [XLEN-1:0]   q_o;
    logic              misaligned_o;
    logic              pagefault_o;

    modport master (
        input  flush_i, req_i, adr_i, size_i, lock_i, we_i, d_i, misaligned_i, pagefault_i,
        output stall_o,
        output biu_stb_o, biu_adr_o, biu_size_o, biu_lock_o, biu_we_o, biu_d_o,
        input  biu_stb_ack_i, biu_ack_i, biu_err_i, biu_q_i,
        output ack_o, err_o, q_o, misaligned_o, pagefault_o
    );

    modport slave (
        output flush_i, req_i, adr_i, size_i, lock_i, we_i, d_i, misaligned_i, pagefault_i,
        input  stall_o,
        input  biu_stb_o, biu_adr_o, biu_size_o, biu_lock_o, biu_we_o, biu_d_o,
        output biu_stb_ack_i, biu_ack_i, biu_err_i, biu_q_i,
        input  ack_o, err_o, q_o, misaligned_o, pagefault_o
    );
endinterface

// File: rtl/riscv_memreq_issue.sv
// Memory request issuer: holds the BIU strobe until accepted, tracks up to DEPTH
// outstanding transfers, emits in-order exception pulses and swallows flushed responses.
module riscv_memreq_issue #(
    parameter int XLEN  = 32,
    parameter int PLEN  = (XLEN == 32) ? 34 : 56,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    riscv_memreq_issue_if.master   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, EXCPT} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [CW-1:0]     r_disc, w_disc_nxt;
    logic              r_drop, w_drop_nxt;

    logic [PLEN-1:0]   r_adr;
    logic [2:0]        r_size;
    logic              r_lock, r_we;
    logic [XLEN-1:0]   r_d;
    logic              r_ack, r_err, r_pf, r_ma;
    logic [XLEN-1:0]   r_q;

    logic w_stb, w_stb_acc, w_resp, w_exc, w_stall, w_accept, w_load, w_deliver;

    assign w_stb     = (r_state == ISSUE);
    assign w_stb_acc = w_stb & bus.biu_stb_ack_i;
    assign w_resp    = (bus.biu_ack_i | bus.biu_err_i) & (r_cnt != '0);
    assign w_exc     = bus.misaligned_i | bus.pagefault_i;

    // An exception request waits until everything ahead of it has drained so
    // that its pulse stays in program order with the bus responses.
    assign w_stall = (w_stb & (!bus.biu_stb_ack_i | (r_cnt == CNT_LAST)))
                   | (r_cnt == CNT_MAX)
                   | (r_state == EXCPT)
                   | (bus.req_i & w_exc & ((r_cnt != '0) | w_stb));

    assign w_accept  = bus.req_i & !w_stall & !bus.flush_i;
    assign w_load    = w_accept & !w_exc;
    assign w_deliver = w_resp & (r_disc == '0) & !bus.flush_i;
    assign w_cnt_nxt = r_cnt + CW'(w_stb_acc) - CW'(w_resp);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = w_accept ? (w_exc ? EXCPT : ISSUE) : IDLE;
            ISSUE: begin
                if (bus.biu_stb_ack_i)
                    w_state_nxt = w_accept ? (w_exc ? EXCPT : ISSUE) : IDLE;
            end
            EXCPT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Responses drain the discard count before a flush reloads it from cnt_next.
    always_comb begin
        w_disc_nxt = r_disc;
        w_drop_nxt = r_drop;
        if (w_resp && (r_disc != '0))
            w_disc_nxt = r_disc - 1'b1;
        if (w_stb_acc && r_drop)
            w_disc_nxt = w_disc_nxt + 1'b1;
        if (w_stb_acc)
            w_drop_nxt = 1'b0;
        if (bus.flush_i) begin
            w_disc_nxt = w_cnt_nxt;
            if (w_stb && !bus.biu_stb_ack_i)
                w_drop_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_disc  <= '0;
            r_drop  <= 1'b0;
            r_adr   <= '0;
            r_size  <= '0;
            r_lock  <= 1'b0;
            r_we    <= 1'b0;
            r_d     <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_q     <= '0;
            r_pf    <= 1'b0;
            r_ma    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_disc  <= w_disc_nxt;
            r_drop  <= w_drop_nxt;
            if (w_load) begin
                r_adr  <= bus.adr_i;
                r_size <= bus.size_i;
                r_lock <= bus.lock_i;
                r_we   <= bus.we_i;
                r_d    <= bus.d_i;
            end
            r_ack <= w_deliver & bus.biu_ack_i;
            r_err <= w_deliver & bus.biu_err_i & !bus.biu_ack_i;
            if (w_deliver)
                r_q <= bus.biu_q_i;
            r_pf <= w_accept & bus.pagefault_i;
            r_ma <= w_accept & !bus.pagefault_i & bus.misaligned_i;
        end
    end

    assign bus.stall_o      = w_stall;
    assign bus.biu_stb_o    = w_stb;
    assign bus.biu_adr_o    = r_adr;
    assign bus.biu_size_o   = r_size;
    assign bus.biu_lock_o   = r_lock;
    assign bus.biu_we_o     = r_we;
    assign bus.biu_d_o      = r_d;
    assign bus.ack_o        = r_ack;
    assign bus.err_o        = r_err;
    assign bus.q_o          = r_q;
    assign bus.pagefault_o  = r_pf;
    assign bus.misaligned_o = r_ma;
endmodule
